// File: rtl/rf_rename_mp_if.sv
// Dispatch/commit/operand-read bundle for rf_rename_mp.
// The master side is dispatch/ROB; the slave side is the register file.
interface rf_rename_mp_if #(
  parameter int XLEN     = 32,
  parameter int REG_NUM  = 32,
  parameter int TAG_W    = 4,
  parameter int NUM_DISP = 2,
  parameter int NUM_CMT  = 2
);
  localparam int RW = (REG_NUM > 1) ? $clog2(REG_NUM) : 1;

  logic [NUM_CMT-1:0]          cmt_valid;
  logic [NUM_CMT*RW-1:0]       cmt_rd;
  logic [NUM_CMT*XLEN-1:0]     cmt_value;
  logic [NUM_CMT*TAG_W-1:0]    cmt_tag;
  logic [NUM_DISP-1:0]         disp_valid;
  logic [NUM_DISP*RW-1:0]      disp_rd;
  logic [NUM_DISP*TAG_W-1:0]   disp_tag;
  logic [2*NUM_DISP*RW-1:0]    rd_idx;
  logic [2*NUM_DISP*XLEN-1:0]  rd_value;
  logic [2*NUM_DISP-1:0]       rd_busy;
  logic [2*NUM_DISP*TAG_W-1:0] rd_tag;

  modport master (
    output cmt_valid, cmt_rd, cmt_value, cmt_tag,
    output disp_valid, disp_rd, disp_tag, rd_idx,
    input  rd_value, rd_busy, rd_tag
  );

  modport slave (
    input  cmt_valid, cmt_rd, cmt_value, cmt_tag,
    input  disp_valid, disp_rd, disp_tag, rd_idx,
    output rd_value, rd_busy, rd_tag
  );
endinterface

// File: rtl/rf_rename_mp.sv
// Multi-port architectural register file with rename/busy table and commit bypass.
// Define RF_CKPT_EN to add tag/busy snapshot save/restore for misprediction recovery.
module rf_rename_mp #(
  parameter int XLEN     = 32,
  parameter int REG_NUM  = 32,
  parameter int TAG_W    = 4,
  parameter int NUM_DISP = 2,
  parameter int NUM_CMT  = 2
`ifdef RF_CKPT_EN
  ,
  parameter int NUM_CKPT = 4,
  localparam int CW = (NUM_CKPT > 1) ? $clog2(NUM_CKPT) : 1
`endif
) (
  input  logic          clk_in,
  input  logic          rst_in,
  input  logic          rdy_in,
  input  logic          flush_in,
`ifdef RF_CKPT_EN
  input  logic          ckpt_save,
  input  logic [CW-1:0] ckpt_save_id,
  input  logic          ckpt_rest,
  input  logic [CW-1:0] ckpt_rest_id,
`endif
  rf_rename_mp_if.slave bus
);
  localparam int RW  = (REG_NUM > 1) ? $clog2(REG_NUM) : 1;
  localparam int NRD = 2 * NUM_DISP;

  logic [XLEN-1:0]    regs [REG_NUM];
  logic [TAG_W-1:0]   tags [REG_NUM];
  logic [REG_NUM-1:0] busy;

  logic [RW-1:0]    c_rd  [NUM_CMT];
  logic [XLEN-1:0]  c_val [NUM_CMT];
  logic [TAG_W-1:0] c_tag [NUM_CMT];
  logic [RW-1:0]    d_rd  [NUM_DISP];
  logic [TAG_W-1:0] d_tag [NUM_DISP];

  always_comb begin
    for (int unsigned c = 0; c < NUM_CMT; c++) begin
      c_rd[c]  = bus.cmt_rd[c*RW +: RW];
      c_val[c] = bus.cmt_value[c*XLEN +: XLEN];
      c_tag[c] = bus.cmt_tag[c*TAG_W +: TAG_W];
    end
    for (int unsigned j = 0; j < NUM_DISP; j++) begin
      d_rd[j]  = bus.disp_rd[j*RW +: RW];
      d_tag[j] = bus.disp_tag[j*TAG_W +: TAG_W];
    end
  end

  // Per-register next state; ascending loops make the highest-index port win.
  logic [REG_NUM-1:0] cmt_hit, rel, dsp_hit, nxt_busy;
  logic [XLEN-1:0]    cmt_v   [REG_NUM];
  logic [TAG_W-1:0]   nxt_tag [REG_NUM];

  always_comb begin
    for (int unsigned r = 0; r < REG_NUM; r++) begin
      cmt_hit[r] = 1'b0;
      rel[r]     = 1'b0;
      dsp_hit[r] = 1'b0;
      cmt_v[r]   = regs[r];
      nxt_tag[r] = tags[r];
      for (int unsigned c = 0; c < NUM_CMT; c++) begin
        if (bus.cmt_valid[c] && c_rd[c] == RW'(r)) begin
          cmt_hit[r] = 1'b1;
          cmt_v[r]   = c_val[c];
          if (busy[r] && c_tag[c] == tags[r]) rel[r] = 1'b1;
        end
      end
      for (int unsigned j = 0; j < NUM_DISP; j++) begin
        if (bus.disp_valid[j] && d_rd[j] == RW'(r)) begin
          dsp_hit[r] = 1'b1;
          nxt_tag[r] = d_tag[j];
        end
      end
      if (r == 0) begin
        cmt_hit[r] = 1'b0;
        rel[r]     = 1'b0;
        dsp_hit[r] = 1'b0;
        nxt_tag[r] = tags[r];
      end
      nxt_busy[r] = dsp_hit[r] | (busy[r] & ~rel[r]);
    end
  end

  // Operand reads: commit bypass for value, then older-slot renames override busy/tag.
  logic [RW-1:0]    r_idx [NRD];
  logic [XLEN-1:0]  r_val [NRD];
  logic [NRD-1:0]   r_bsy;
  logic [TAG_W-1:0] r_tag [NRD];

  always_comb begin
    for (int unsigned p = 0; p < NRD; p++) begin
      r_idx[p] = bus.rd_idx[p*RW +: RW];
      r_val[p] = regs[r_idx[p]];
      r_bsy[p] = busy[r_idx[p]];
      r_tag[p] = tags[r_idx[p]];
      for (int unsigned c = 0; c < NUM_CMT; c++) begin
        if (bus.cmt_valid[c] && c_rd[c] == r_idx[p]) begin
          r_val[p] = c_val[c];
          if (c_tag[c] == tags[r_idx[p]]) r_bsy[p] = 1'b0;
        end
      end
      for (int unsigned j = 0; j < NUM_DISP; j++) begin
        if (j < p / 2 && bus.disp_valid[j] && d_rd[j] == r_idx[p]) begin
          r_bsy[p] = 1'b1;
          r_tag[p] = d_tag[j];
        end
      end
      if (r_idx[p] == '0) begin
        r_val[p] = '0;
        r_bsy[p] = 1'b0;
        r_tag[p] = '0;
      end
      bus.rd_value[p*XLEN +: XLEN] = r_val[p];
      bus.rd_tag[p*TAG_W +: TAG_W] = r_tag[p];
    end
    bus.rd_busy = r_bsy;
  end

`ifdef RF_CKPT_EN
  logic [REG_NUM-1:0] ck_busy [NUM_CKPT];
  logic [TAG_W-1:0]   ck_tag  [NUM_CKPT][REG_NUM];
  logic [REG_NUM-1:0] ck_rel  [NUM_CKPT];

  // Snapshots retire their pending entries as the matching producers commit.
  always_comb begin
    for (int unsigned s = 0; s < NUM_CKPT; s++) begin
      for (int unsigned r = 0; r < REG_NUM; r++) begin
        ck_rel[s][r] = 1'b0;
        for (int unsigned c = 0; c < NUM_CMT; c++) begin
          if (bus.cmt_valid[c] && c_rd[c] == RW'(r) && c_tag[c] == ck_tag[s][r] && ck_busy[s][r])
            ck_rel[s][r] = 1'b1;
        end
      end
    end
  end
`endif

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      for (int unsigned r = 0; r < REG_NUM; r++) begin
        regs[r] <= '0;
        tags[r] <= '0;
      end
      busy <= '0;
`ifdef RF_CKPT_EN
      for (int unsigned s = 0; s < NUM_CKPT; s++) begin
        ck_busy[s] <= '0;
        for (int unsigned r = 0; r < REG_NUM; r++) ck_tag[s][r] <= '0;
      end
`endif
    end else if (rdy_in) begin
      if (flush_in) begin
        busy <= '0;
      end else begin
        for (int unsigned r = 0; r < REG_NUM; r++) begin
          if (cmt_hit[r]) regs[r] <= cmt_v[r];
        end
`ifdef RF_CKPT_EN
        for (int unsigned s = 0; s < NUM_CKPT; s++) ck_busy[s] <= ck_busy[s] & ~ck_rel[s];
        if (ckpt_rest) begin
          busy <= ck_busy[ckpt_rest_id] & ~ck_rel[ckpt_rest_id];
          for (int unsigned r = 0; r < REG_NUM; r++) tags[r] <= ck_tag[ckpt_rest_id][r];
        end else begin
          busy <= nxt_busy;
          for (int unsigned r = 0; r < REG_NUM; r++) tags[r] <= nxt_tag[r];
          // Later assignment overrides the commit-observation update of the saved slot.
          if (ckpt_save) begin
            ck_busy[ckpt_save_id] <= nxt_busy;
            for (int unsigned r = 0; r < REG_NUM; r++) ck_tag[ckpt_save_id][r] <= nxt_tag[r];
          end
        end
`else
        busy <= nxt_busy;
        for (int unsigned r = 0; r < REG_NUM; r++) tags[r] <= nxt_tag[r];
`endif
      end
    end
  end
endmodule

// File: doc/rf_rename_mp.md
Name: rf_rename_mp

Overview:
- Parametrised multi-port architectural register file with a rename/dependency table, for a superscalar out-of-order core.
- Sits between the decoder/dispatch stage (rename writes, operand reads) and ROB commit (value writeback, dependency release).
- Supports N dispatch slots and M commit ports per cycle.
- Busy state is held in an explicit valid bit, not a sentinel tag value.

Parameters:
- XLEN, 32, register data width
- REG_NUM, 32, number of architectural registers; index width RW = $clog2(REG_NUM)
- TAG_W, 4, ROB tag width
- NUM_DISP, 2, dispatch slots per cycle; each slot owns 2 read ports (rs1, rs2)
- NUM_CMT, 2, commit ports per cycle; higher index = younger in program order
- NUM_CKPT, 4, snapshot slots (only with RF_CKPT_EN); CW = $clog2(NUM_CKPT)

Ports:
- clk_in  in  1  clock, rising edge
- rst_in  in  1  asynchronous, active-low reset
- rdy_in  in  1  global ready; low = hold all state
- flush_in  in  1  pipeline flush
- cmt_valid  in  NUM_CMT  commit port valid
- cmt_rd  in  NUM_CMT*RW  commit destination register
- cmt_value  in  NUM_CMT*XLEN  commit value
- cmt_tag  in  NUM_CMT*TAG_W  ROB tag of committing entry
- disp_valid  in  NUM_DISP  dispatch slot valid
- disp_rd  in  NUM_DISP*RW  renamed destination register
- disp_tag  in  NUM_DISP*TAG_W  newly allocated ROB tag
- rd_idx  in  2*NUM_DISP*RW  read indices; port 2k = slot k rs1, port 2k+1 = slot k rs2
- rd_value  out  2*NUM_DISP*XLEN  operand value
- rd_busy  out  2*NUM_DISP  operand pending on a ROB entry
- rd_tag  out  2*NUM_DISP*TAG_W  producing ROB tag; valid only when busy

Behaviour:
- State: regs[REG_NUM] (XLEN), tag[REG_NUM] (TAG_W), busy[REG_NUM] (1).
- Reset (asynchronous, rst_in low): all regs = 0, busy = 0, tag = 0; all outputs therefore read 0 / not busy.
- rdy_in low: no state change. Read outputs remain combinational.
- Register 0:
  - Never written, never busy.
  - Reads return value 0, busy 0, tag 0, regardless of bypass.
- Reads are combinational, zero latency. For read port p of slot k, index r:
  - Value: if any valid commit port targets r this cycle, take the highest-index such port's cmt_value; else regs[r].
  - Dependency: if any dispatch slot j<k with disp_valid renames r, take the highest such j: busy = 1, tag = disp_tag[j].
  - Else if busy[r] and a valid commit port has cmt_rd == r and cmt_tag == tag[r]: busy = 0.
  - Else busy = busy[r], tag = tag[r].
  - A slot never sees its own rename, nor renames from younger slots.
- Clock edge, rdy_in high, flush_in low:
  - Commit: for each r, regs[r] <= value of the highest-index valid commit port targeting r.
  - Release: busy[r] <= 0 if some valid commit has cmt_rd == r and cmt_tag == tag[r], and no dispatch renames r this cycle.
  - A tag mismatch writes the value but leaves busy/tag unchanged (a younger producer is still pending).
  - Dispatch: busy[r] <= 1 and tag[r] <= disp_tag of the highest-index valid slot renaming r. Dispatch overrides a same-cycle release.
- flush_in high (with rdy_in high): busy[*] <= 0; regs and tags retained; same-cycle commits and dispatches are ignored.
- Tags are not range-checked; the ROB guarantees uniqueness among live tags.

Optional Feature:
- Macro: RF_CKPT_EN.
- Extra ports, present only with the macro:
  - ckpt_save  in  1
  - ckpt_save_id  in  CW
  - ckpt_rest  in  1
  - ckpt_rest_id  in  CW
- With RF_CKPT_EN:
  - Save: copies the post-dispatch tag/busy table (including this cycle's renames) into slot ckpt_save_id at the edge.
  - Live snapshots also observe commits: a snapshot busy bit clears when a commit's rd/tag matches the snapshot entry.
  - Restore: at the edge, loads tag/busy from slot ckpt_rest_id. Commit releases that match the snapshot apply in the same cycle; same-cycle dispatches are ignored.
  - Priority: flush_in > restore > normal; save is ignored when restore or flush is asserted.
  - Reset clears all snapshots to not-busy.
- Without the macro: the snapshot ports and storage do not exist; behaviour is as above.

Test Plan:
- Reset: rst_in low mid-cycle -> all rd_busy = 0 and rd_value = 0 immediately, without waiting for a clock edge.
- Dispatch x5 with tag 3 on slot 0, slot 1 reads x5 -> slot 1 sees busy = 1, tag = 3; slot 0 rs1 = x5 shows the old state.
  - Next cycle: both slots see busy = 1, tag = 3.
- Commit x5, value 0xDEADBEEF, tag 3 -> same cycle: value 0xDEADBEEF, busy = 0. Next cycle: regs[5] = 0xDEADBEEF, busy = 0.
- Stale commit: x5 renamed to tag 3 then tag 7; commit x5 with tag 3 -> value written, busy stays 1, tag = 7.
- Same-cycle ports:
  - Commit ports 0 and 1 both write x9 (values 1 and 2) -> regs[9] = 2.
  - Dispatch x9 on slots 0 and 1 (tags 4 and 6) -> tag = 6.
  - Write to x0 -> x0 reads 0, not busy.
- Checkpoint (RF_CKPT_EN): save slot 1 with x3 busy on tag 2; commit tag 2; dispatch x3 tag 5; restore slot 1 -> x3 not busy.
- Flush with 8 busy registers -> next cycle all not busy, values unchanged.
